// File: rtl/rvvi_tx_scheduler.sv
// rvvi_tx_scheduler: picks the single RVVI Ethernet TX slot between fresh packets and active-list replays.
// Latency: a packet loaded on cycle N is presented on TxValid/TxData on cycle N+1 (one output register).
// Backpressure: TxValid & ~TxReady closes the slot, so FreshReady=0 and ReplayStall=1 until the MAC takes it.
//
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   FreshValid/FreshData/FreshReady packetizer handshake (FreshReady is the accept strobe)
//   AlPort1Wen/AlPort1WData         active-list insert of every fresh packet sent
//   AlFull/AlEmpty/AlWait           active-list status
//   ReplayValid/ReplayData          active-list replay read port (Port3)
//   ReplayStall                     active-list replay stall (Port3Stall)
//   AckSeen                         host ack processed by the active list
//   TxValid/TxData/TxReady          registered packet to the MAC
//   Timeout                         one-cycle pulse on ack watchdog expiry
//   ReplayCount/TimeoutCount        replays sent (wrapping), timeouts (saturating)
module rvvi_tx_scheduler #(
  parameter int WIDTH        = 792,
  parameter int TIMEOUT_BITS = 16,
  parameter int TIMEOUT      = 50000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             FreshValid,
  input  logic [WIDTH-1:0] FreshData,
  output logic             FreshReady,
  output logic             AlPort1Wen,
  output logic [WIDTH-1:0] AlPort1WData,
  input  logic             AlFull,
  input  logic             AlEmpty,
  input  logic             AlWait,
  input  logic             ReplayValid,
  input  logic [WIDTH-1:0] ReplayData,
  output logic             ReplayStall,
  input  logic             AckSeen,
  output logic             TxValid,
  output logic [WIDTH-1:0] TxData,
  input  logic             TxReady,
  output logic             Timeout,
  output logic [15:0]      ReplayCount,
  output logic [7:0]       TimeoutCount
);

  typedef enum logic [1:0] {
    S_NORMAL = 2'd0,
    S_REPLAY = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  localparam logic [TIMEOUT_BITS-1:0] TIMER_MAX = TIMEOUT_BITS'(TIMEOUT - 1);

  state_t                  state;
  logic [TIMEOUT_BITS-1:0] timer;

  logic slot_free;
  logic replay_load;
  logic timer_clear;
  logic timer_expire;

  // The output register can take a new packet if it is empty or being drained this cycle.
  assign slot_free = ~TxValid | TxReady;

  // ReplayValid is a combinational function of ReplayStall inside the active list,
  // so the stall is built only from registered state and non-replay inputs.
  assign ReplayStall = ~(resetn & AlWait & slot_free);
  assign replay_load = ReplayValid & ~ReplayStall;

  // AlWait gates fresh traffic entirely, so a replay and a fresh load can never coincide.
  assign FreshReady   = resetn & FreshValid & slot_free & ~AlWait & ~AlFull & (state == S_NORMAL);
  assign AlPort1Wen   = FreshReady;
  assign AlPort1WData = FreshData;

  // The watchdog only runs while the host owes us an ack and no replay is in progress.
  assign timer_clear  = AckSeen | AlEmpty | AlWait;
  assign timer_expire = (state == S_NORMAL) & (timer == TIMER_MAX) & ~timer_clear;

  // Output stage: data holds whenever nothing new is loaded.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      TxValid     <= 1'b0;
      TxData      <= '0;
      ReplayCount <= '0;
    end else begin
      if (replay_load) begin
        TxValid     <= 1'b1;
        TxData      <= ReplayData;
        ReplayCount <= ReplayCount + 16'd1;
      end else if (FreshReady) begin
        TxValid <= 1'b1;
        TxData  <= FreshData;
      end else if (TxReady) begin
        TxValid <= 1'b0;
      end
    end
  end

  // Watchdog timer: saturates at TIMER_MAX so HOLD does not produce repeated pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer <= '0;
    end else if (timer_clear) begin
      timer <= '0;
    end else if (timer != TIMER_MAX) begin
      timer <= timer + 1'b1;
    end
  end

  // Mode FSM with its registered outputs (Timeout pulse and TimeoutCount).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_NORMAL;
      Timeout      <= 1'b0;
      TimeoutCount <= '0;
    end else begin
      Timeout <= timer_expire;
      if (timer_expire && TimeoutCount != 8'hFF) begin
        TimeoutCount <= TimeoutCount + 8'd1;
      end
      if (AlWait) begin
        state <= S_REPLAY;
      end else begin
        unique case (state)
          S_NORMAL: if (timer_expire) state <= S_HOLD;
          S_REPLAY: state <= S_NORMAL;
          S_HOLD:   if (AckSeen || AlEmpty) state <= S_NORMAL;
          default:  state <= S_NORMAL;
        endcase
      end
    end
  end

endmodule

// File: doc/rvvi_tx_scheduler.md
Name: rvvi_tx_scheduler

Overview:
- Sequences the single RVVI Ethernet transmit path between two sources:
  - fresh instruction packets from the RVVI packetizer;
  - replay packets read out of the RVVI active list.
- Writes every fresh packet it sends into the active list (port 1), and drives the active list's replay stall (port 3).
- Runs an acknowledgement watchdog that blocks fresh traffic when the host stops acking.

Parameters:
- WIDTH, 792, packet width in bits (matches active-list entry width).
- TIMEOUT_BITS, 16, width of the ack watchdog timer.
- TIMEOUT, 50000, cycles without an ack (active list non-empty) before a timeout.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- FreshValid  in  1  packetizer has a packet.
- FreshData  in  WIDTH  packetizer packet.
- FreshReady  out  1  fresh packet accepted this cycle.
- AlPort1Wen  out  1  active-list insert strobe.
- AlPort1WData  out  WIDTH  active-list insert data.
- AlFull  in  1  active-list full.
- AlEmpty  in  1  active-list empty.
- AlWait  in  1  active list in replay/wait.
- ReplayValid  in  1  active-list Port3RValid.
- ReplayData  in  WIDTH  active-list Port3RData.
- ReplayStall  out  1  active-list Port3Stall.
- AckSeen  in  1  ack processed (active-list Port2Wen).
- TxValid  out  1  packet valid to MAC.
- TxData  out  WIDTH  packet to MAC.
- TxReady  in  1  MAC accepts packet.
- Timeout  out  1  one-cycle pulse on watchdog expiry.
- ReplayCount  out  16  replay packets sent, wrapping.
- TimeoutCount  out  8  timeouts, saturating at 255.

Behaviour:
- Output stage:
  - TxValid and TxData are registered.
  - SlotFree = ~TxValid | TxReady.
  - A packet loaded on cycle N appears at TxValid on cycle N+1.
  - TxData holds stable while TxValid & ~TxReady.
- Combinational-loop rule: ReplayValid depends combinationally on ReplayStall, so ReplayStall must not depend on ReplayValid, ReplayData or FreshValid.
- State machine (registered): NORMAL, REPLAY, HOLD.
  - NORMAL -> REPLAY when AlWait.
  - NORMAL -> HOLD on timer expiry.
  - REPLAY -> NORMAL when ~AlWait.
  - HOLD -> REPLAY when AlWait.
  - HOLD -> NORMAL when AckSeen | AlEmpty, with AlWait low.
  - AlWait has priority over all other transitions.
- Replay path:
  - ReplayStall = ~(AlWait & SlotFree).
  - When ReplayValid & ~ReplayStall, load ReplayData into the output register and increment ReplayCount.
- Fresh path:
  - FreshReady = FreshValid & SlotFree & ~AlWait & ~AlFull & State==NORMAL.
  - When FreshReady: load FreshData into the output register, and in the same cycle assert AlPort1Wen with AlPort1WData = FreshData.
  - AlPort1Wen is combinational and equal to FreshReady.
  - The packet is never sent without being inserted, nor inserted without being sent.
- Simultaneous sources: AlWait high gates fresh entirely, so replay wins and fresh waits. Never load two packets in one cycle.
- Watchdog timer (TIMEOUT_BITS):
  - Cleared when AckSeen | AlEmpty | AlWait; otherwise increments.
  - When timer == TIMEOUT-1 while in NORMAL: assert Timeout for one cycle, increment TimeoutCount (saturating), enter HOLD.
  - Timer saturates at TIMEOUT-1 while in HOLD; no further Timeout pulses until it is cleared and re-expires.
- Reset (resetn==0 at clk edge):
  - State=NORMAL; TxValid=0; TxData=0; timer=0; ReplayCount=0; TimeoutCount=0; Timeout=0.
  - Combinational outputs FreshReady=0, AlPort1Wen=0 and ReplayStall=1 while resetn low.
  - Reset mid-transfer drops any pending TxValid packet; no recovery of that packet.
- Back-pressure: with TxReady low and TxValid high, SlotFree=0, so FreshReady=0 and ReplayStall=1 regardless of state.

Test Plan:
- Fresh only: AlWait=0, AlFull=0, TxReady=1, three back-to-back FreshValid packets A,B,C -> FreshReady/AlPort1Wen high three cycles; TxData=A,B,C on cycles 1..3 after acceptance; ReplayCount=0.
- Back-pressure: TxReady=0 for 5 cycles with packet A held -> TxData stays A; FreshReady=0; ReplayStall=1. Release TxReady -> next packet loads in the following cycle.
- Replay priority: FreshValid=1, AlWait=1, active list replays 2 entries -> TxData carries both replays; FreshReady=0 throughout; ReplayCount=2. After AlWait falls, fresh resumes in the next cycle.
- Full: AlFull=1, FreshValid=1 -> FreshReady=0 and AlPort1Wen=0 indefinitely. AlFull falls -> accepted in the same cycle.
- Watchdog: TIMEOUT=8, AlEmpty=0, no AckSeen -> Timeout pulses once at the 8th cycle; TimeoutCount=1; fresh blocked in HOLD. AckSeen -> NORMAL next cycle; fresh resumes.
- Reset mid-operation: resetn=0 while TxValid=1 and in HOLD -> next cycle TxValid=0, state NORMAL, counters 0; ReplayStall=1 during reset.
